// File: rtl/medidor_pkg.sv
// Shared constants for the period meter: FSM state encoding, default sizes
// and the averaging window depth.
package medidor_pkg;

  // FSM state encoding
  localparam logic [1:0] ESPERA   = 2'd0;
  localparam logic [1:0] MIDIENDO = 2'd1;
  localparam logic [1:0] SATURADO = 2'd2;

  // Default sizes
  localparam int unsigned ANCHO_DEF       = 16;
  localparam int unsigned ETAPAS_SYNC_DEF = 2;

  // Depth of the optional averaging window (must be a power of two)
  localparam int unsigned PROMEDIO_N = 4;

endpackage

// File: rtl/sincronizador_flanco.sv
// Synchronizer chain plus history flop producing a one-cycle rising-edge
// strobe for an untrusted single-bit input. Also used for button inputs.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset (clears chain and history)
//   senal  - raw input
//   flanco - high for one cycle per synchronized rising edge of senal
module sincronizador_flanco #(
  parameter int unsigned ETAPAS_SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic senal,
  output logic flanco
);

  logic [ETAPAS_SYNC-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[ETAPAS_SYNC-2:0], senal};
      hist_q <= sync_q[ETAPAS_SYNC-1];
    end
  end

  assign flanco = sync_q[ETAPAS_SYNC-1] & ~hist_q;

endmodule

// File: rtl/medidor_periodo.sv
// Period meter: counts clk cycles between successive rising edges of senal
// and reports each completed period with a one-cycle valid strobe. Periods
// that reach 2^ANCHO-1 cycles without an edge saturate and set desborde.
//
// Optional build macro MEDIDOR_PERIODO_PROMEDIO_EN: reports the truncated
// mean of the last PROMEDIO_N raw periods instead of each raw period.
//
// Ports:
//   clk            - system clock, rising edge
//   rst            - synchronous active-high reset
//   senal          - signal under measurement (synchronized internally)
//   habilitar      - 1 measures; 0 holds outputs and returns to ESPERA
//   periodo        - last measured period in clk cycles
//   periodo_valido - one-cycle pulse when periodo updates
//   desborde       - sticky: last attempt exceeded 2^ANCHO-1 cycles
module medidor_periodo
  import medidor_pkg::*;
#(
  parameter int unsigned ANCHO       = ANCHO_DEF,
  parameter int unsigned ETAPAS_SYNC = ETAPAS_SYNC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             senal,
  input  logic             habilitar,
  output logic [ANCHO-1:0] periodo,
  output logic             periodo_valido,
  output logic             desborde
);

  localparam logic [ANCHO-1:0] MAXIMO = '1;
  localparam logic [ANCHO-1:0] UNO    = ANCHO'(1);

  logic flanco;

  sincronizador_flanco #(
    .ETAPAS_SYNC(ETAPAS_SYNC)
  ) u_sinc (
    .clk   (clk),
    .rst   (rst),
    .senal (senal),
    .flanco(flanco)
  );

  logic [1:0]       estado_q, estado_d;
  logic [ANCHO-1:0] contador_q, contador_d;
  logic [ANCHO-1:0] periodo_q, periodo_d;
  logic             valido_q, valido_d;
  logic             desborde_q, desborde_d;
  logic             medida;   // a full period ended this cycle
  logic             saturar;  // counter ran out without an edge

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    medida     = 1'b0;
    saturar    = 1'b0;
    if (!habilitar) begin
      estado_d   = ESPERA;
      contador_d = '0;
    end else begin
      case (estado_q)
        ESPERA: begin
          // Partial first period is discarded
          if (flanco) begin
            contador_d = UNO;
            estado_d   = MIDIENDO;
          end
        end
        MIDIENDO: begin
          // An edge on the terminal count is still a valid measurement
          if (flanco) begin
            medida     = 1'b1;
            contador_d = UNO;
          end else if (contador_q == MAXIMO) begin
            saturar  = 1'b1;
            estado_d = SATURADO;
          end else begin
            contador_d = contador_q + UNO;
          end
        end
        SATURADO: begin
          if (flanco) begin
            contador_d = UNO;
            estado_d   = MIDIENDO;
          end
        end
        default: begin
          estado_d   = ESPERA;
          contador_d = '0;
        end
      endcase
    end
  end

`ifdef MEDIDOR_PERIODO_PROMEDIO_EN
  localparam int unsigned LOG_N = $clog2(PROMEDIO_N);

  logic [ANCHO-1:0] ventana_q [PROMEDIO_N];
  logic [ANCHO-1:0] ventana_d [PROMEDIO_N];
  logic [2:0]       cuenta_q, cuenta_d;
  logic [ANCHO+1:0] suma;

  always_comb begin
    periodo_d  = periodo_q;
    valido_d   = 1'b0;
    desborde_d = desborde_q;
    ventana_d  = ventana_q;
    cuenta_d   = cuenta_q;
    suma       = '0;
    if (saturar) begin
      // Saturation bypasses and empties the window
      periodo_d  = MAXIMO;
      desborde_d = 1'b1;
      valido_d   = 1'b1;
      cuenta_d   = '0;
    end else if (!habilitar || estado_q == ESPERA) begin
      cuenta_d = '0;
    end else if (medida) begin
      ventana_d[0] = contador_q;
      for (int i = 1; i < PROMEDIO_N; i++) begin
        ventana_d[i] = ventana_q[i-1];
      end
      if (cuenta_q != 3'(PROMEDIO_N)) begin
        cuenta_d = cuenta_q + 3'd1;
      end
      for (int i = 0; i < PROMEDIO_N; i++) begin
        suma = suma + {2'b00, ventana_d[i]};
      end
      if (cuenta_d == 3'(PROMEDIO_N)) begin
        periodo_d  = ANCHO'(suma >> LOG_N);
        desborde_d = 1'b0;
        valido_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cuenta_q <= '0;
      for (int i = 0; i < PROMEDIO_N; i++) begin
        ventana_q[i] <= '0;
      end
    end else begin
      cuenta_q  <= cuenta_d;
      ventana_q <= ventana_d;
    end
  end
`else
  always_comb begin
    periodo_d  = periodo_q;
    valido_d   = 1'b0;
    desborde_d = desborde_q;
    if (medida) begin
      periodo_d  = contador_q;
      desborde_d = 1'b0;
      valido_d   = 1'b1;
    end else if (saturar) begin
      periodo_d  = MAXIMO;
      desborde_d = 1'b1;
      valido_d   = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= ESPERA;
      contador_q <= '0;
      periodo_q  <= '0;
      valido_q   <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      periodo_q  <= periodo_d;
      valido_q   <= valido_d;
      desborde_q <= desborde_d;
    end
  end

  assign periodo        = periodo_q;
  assign periodo_valido = valido_q;
  assign desborde       = desborde_q;

endmodule

// File: tb/tb_medidor_periodo.sv
// Self-checking bench for medidor_periodo (default build). The reference
// model keeps the timestamp of the last accepted rising edge and reports
// the difference to the next one, or saturation after 65535 cycles.
module tb_medidor_periodo;

  logic        clk;
  logic        rst;
  logic        senal;
  logic        habilitar;
  logic [15:0] periodo;
  logic        periodo_valido;
  logic        desborde;

  medidor_periodo dut (
    .clk           (clk),
    .rst           (rst),
    .senal         (senal),
    .habilitar     (habilitar),
    .periodo       (periodo),
    .periodo_valido(periodo_valido),
    .desborde      (desborde)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          ciclo = 0;
  bit          tiene_inicio = 0;
  bit          saturado = 0;
  int          t_inicio = 0;
  logic [2:0]  retardo = '0;  // input delay line: [0],[1] sync, [2] history
  logic [15:0] e_periodo = '0;
  logic        e_valido = 1'b0;
  logic        e_desborde = 1'b0;

  task automatic modelo();
    bit ev;
    ev = retardo[1] & ~retardo[2];
    ciclo++;
    e_valido = 1'b0;
    if (rst) begin
      retardo = '0;
      tiene_inicio = 0;
      saturado = 0;
      e_periodo = '0;
      e_desborde = 1'b0;
    end else begin
      retardo = {retardo[1:0], senal};
      if (!habilitar) begin
        tiene_inicio = 0;
      end else if (ev) begin
        if (tiene_inicio && !saturado) begin
          e_periodo = 16'(ciclo - t_inicio);
          e_desborde = 1'b0;
          e_valido = 1'b1;
        end
        tiene_inicio = 1;
        saturado = 0;
        t_inicio = ciclo;
      end else if (tiene_inicio && !saturado && (ciclo - t_inicio) == 65535) begin
        e_periodo = 16'hFFFF;
        e_desborde = 1'b1;
        e_valido = 1'b1;
        saturado = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelo();
    #1;
    checks++;
    assert (periodo === e_periodo) else begin
      errors++;
      $error("FAIL periodo ciclo %0d: obtenido %0d esperado %0d", ciclo, periodo, e_periodo);
    end
    checks++;
    assert (periodo_valido === e_valido) else begin
      errors++;
      $error("FAIL periodo_valido ciclo %0d: obtenido %b esperado %b", ciclo, periodo_valido,
             e_valido);
    end
    checks++;
    assert (desborde === e_desborde) else begin
      errors++;
      $error("FAIL desborde ciclo %0d: obtenido %b esperado %b", ciclo, desborde, e_desborde);
    end
  endtask

  task automatic paso(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      senal = v;
      tick();
    end
  endtask

  task automatic onda(input int alto, input int bajo, input int veces);
    for (int i = 0; i < veces; i++) begin
      paso(1'b1, alto);
      paso(1'b0, bajo);
    end
  endtask

  task automatic comprobar(input string tag, input logic [15:0] p, input logic d);
    checks++;
    assert (periodo === p && desborde === d) else begin
      errors++;
      $error("FAIL %s: obtenido periodo=%0d desborde=%b esperado periodo=%0d desborde=%b",
             tag, periodo, desborde, p, d);
    end
  endtask

  initial begin
    rst = 1'b1;
    senal = 1'b0;
    habilitar = 1'b0;
    paso(1'b0, 3);
    comprobar("reset", 16'd0, 1'b0);
    rst = 1'b0;
    habilitar = 1'b1;
    paso(1'b0, 2);

    // 5 high / 5 low
    onda(5, 5, 6);
    comprobar("onda_10", 16'd10, 1'b0);

    // 1 high / 1 low
    onda(1, 1, 20);
    comprobar("onda_2", 16'd2, 1'b0);

    // Random square waves
    for (int i = 0; i < 30; i++) begin
      onda(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1);
    end

    // Saturation: one edge then held low
    paso(1'b1, 3);
    paso(1'b0, 65545);
    comprobar("saturado", 16'hFFFF, 1'b1);
    onda(5, 5, 4);
    comprobar("tras_saturar", 16'd10, 1'b0);

    // Reset 4 clocks into a period
    onda(5, 5, 3);
    paso(1'b1, 4);
    rst = 1'b1;
    paso(1'b1, 1);
    comprobar("reset_medio", 16'd0, 1'b0);
    rst = 1'b0;
    paso(1'b0, 5);
    onda(5, 5, 4);
    comprobar("tras_reset", 16'd10, 1'b0);

    // habilitar dropped for 20 clocks
    habilitar = 1'b0;
    onda(5, 5, 2);
    comprobar("deshabilitado", 16'd10, 1'b0);
    habilitar = 1'b1;
    onda(7, 5, 3);
    comprobar("rehabilitado", 16'd12, 1'b0);

    // Random bit stream with occasional disable and reset
    for (int i = 0; i < 600; i++) begin
      habilitar = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 99) == 0);
      paso(1'($urandom_range(0, 1)), 1);
    end
    rst = 1'b0;
    habilitar = 1'b1;
    onda(4, 4, 4);
    comprobar("final", 16'd8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
